fp_mac_acc_seq: RTL and testbench
=================================

# fp_mac_acc_seq

Parametrised serial floating-point accumulator that sums a configurable number of FloPoCo 8/23 products (34-bit: 2-bit exception, sign, 8-bit exponent, 23-bit mantissa) through one pipelined `FPAdd_8_23_F400_uid2` instance. It sits behind the FP multiplier in each convolution/dense MAC lane. It replaces fixed-count accumulators with:
- a runtime term count,
- an optional bias preload,
- valid/ready handshakes on both sides.

## Interface
- `MAX_TERMS`, 25 — largest term count accepted per accumulation.
- `ADD_LAT`, 13 — pipeline depth of the FP adder instance. It must equal the adder's depth.
- `CNT_W`, `$clog2(MAX_TERMS+1)` — width of the term count and term counter.
- `W`, 34 — FloPoCo word width. It is fixed at 34 for the 8/23 adder.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `RST_n`  in  1  — asynchronous, active-low reset.
- `start`  in  1  — starts a new accumulation. Sampled only when the block can accept a start.
- `cfg_terms`  in  `CNT_W`  — number of products to sum. Latched on an accepted `start`.
- `cfg_bias_en`  in  1  — 1: initial accumulator value is `bias`; 0: initial value is +0. Latched on an accepted `start`.
- `bias`  in  `W`  — FloPoCo bias value. Latched on an accepted `start`.
- `in_valid`  in  1  — product word available.
- `in_data`  in  `W`  — product from the multiplier.
- `in_ready`  out  1  — block will take `in_data` this cycle.
- `out_valid`  out  1  — `out_data` holds the final sum.
- `out_data`  out  `W`  — accumulated result.
- `out_ready`  in  1  — consumer takes the result.
- `busy`  out  1  — high in any state other than IDLE.
- `terms_done`  out  `CNT_W`  — number of terms folded into the accumulator so far.
- `err`  out  1  — one-cycle pulse on a configuration or protocol violation.

## Operation
- FSM states: IDLE, WAIT_IN, ADD, DONE.
- Start acceptance:
  - `start` is accepted in IDLE, or in DONE when `out_ready` is also high (back-to-back operation).
  - On accept: `acc` ← (`cfg_bias_en` ? `bias` : 0x0_0000_0000); `terms_done` ← 0; the latched term count `n` ← `cfg_terms`.
- Term-count saturation:
  - If `cfg_terms` > `MAX_TERMS`: `n` ← `MAX_TERMS` and `err` pulses.
- Zero terms: if `n` == 0, go to DONE directly with `out_data` = initial `acc`. Otherwise go to WAIT_IN.
- WAIT_IN:
  - `in_ready` = 1.
  - On `in_valid`: `op` ← `in_data`, wait counter ← 0, go to ADD.
- ADD:
  - `in_ready` = 0; `op` and `acc` are held stable.
  - The adder computes `op + acc`.
  - When the wait counter reaches `ADD_LAT`−1: `acc` ← adder output and `terms_done` increments.
  - Next state is DONE if `terms_done`+1 == `n`, else WAIT_IN.
- DONE:
  - `out_valid` = 1 and `out_data` = `acc`, both held stable until `out_ready`.
  - On `out_ready`: go to IDLE, or restart if `start` is also high.
- Invalid or ignored inputs:
  - `start` while busy and not in DONE+`out_ready`: ignored, `err` pulses, state unchanged.
  - `in_valid` outside WAIT_IN: ignored, no error.
- Exception handling: exception bits (zero/inf/NaN) pass through the adder unmodified. The block does not inspect them.

## Timing
- Reset values (while `RST_n` = 0):
  - State IDLE.
  - `in_ready`, `out_valid`, `busy`, `err` = 0.
  - `out_data` = 0; `terms_done` = 0; `acc` = 0.
- Reset mid-operation: asserting `RST_n` low at any point aborts at once. No result is produced, and the in-flight adder output is discarded.
- Start timing:
  - `start` accepted at edge S ⇒ `busy` = 1 and `in_ready` = 1 from cycle S+1 when `n` > 0.
  - When `n` == 0, `out_valid` = 1 from cycle S+1.
- Per-term timing:
  - Term accepted at edge E ⇒ `acc` and `terms_done` update at edge E+`ADD_LAT`.
  - `in_ready` returns in the next cycle, so the next accept is at edge E+`ADD_LAT`+1 at the earliest.
- Latency: with `in_valid` held high, `out_valid` rises at edge S + n·(`ADD_LAT`+1).
  - Default `ADD_LAT` with n = 9: 126 cycles.
- Throughput: one term per `ADD_LAT`+1 cycles. Input stalls add cycles one-for-one.
- Back-to-back: a start accepted in DONE (with `out_ready`) behaves as if accepted in IDLE at the same edge. `out_valid` falls at that edge.
- `err`: registered, high for exactly one cycle after the offending edge.

## Test plan
- Nine terms of 1.0:
  - Stimulus: `cfg_terms`=9, `cfg_bias_en`=0, nine `in_data` 0x1_3F80_0000, `in_valid` held high, `out_ready`=1.
  - Response: `out_data` = 0x1_4110_0000 (9.0); `out_valid` 126 cycles after start; `terms_done`=9.
- Bias with stalled input:
  - Stimulus: `cfg_bias_en`=1, `bias`=0x1_4000_0000 (2.0), `cfg_terms`=2, terms 1.0 and 3.0 (0x1_4040_0000), with a 5-cycle `in_valid` gap before the second term.
  - Response: `out_data` = 0x1_40C0_0000 (6.0); `out_valid` 33 cycles after start.
- Zero terms:
  - Stimulus: `cfg_terms`=0, bias 2.0 enabled.
  - Response: `out_valid` the cycle after start with 0x1_4000_0000; `in_ready` never high.
- Saturation and illegal start:
  - Stimulus: `cfg_terms`=31, then `start` pulsed during ADD.
  - Response: `err` pulses once for the saturation, since `n` becomes 25 and exactly 25 terms are accepted. `err` pulses again for the illegal start, and the result is unaffected.
- Back-pressure and back-to-back:
  - Stimulus: hold `out_ready`=0 for 10 cycles after `out_valid`, then `out_ready`=1 together with `start`.
  - Response: `out_data` is stable while held. The second accumulation's first `in_ready` appears the cycle after the handover edge.
- Mid-operation reset:
  - Stimulus: drive `RST_n` low during ADD of term 4 of 9, then restart with 1 term of 1.0.
  - Response: all outputs go to 0 immediately. The restarted run gives 0x1_3F80_0000 after 14 cycles, with no stale `acc` contribution.

Source files
------------

// File: rtl/fp_mac_acc_seq.sv
// Serial FloPoCo 8/23 accumulator: folds a runtime number of products into
// one running sum through a single pipelined FP adder, with optional bias
// preload and valid/ready handshakes on the input and result sides.

module fp_mac_acc_seq #(
  parameter int unsigned MAX_TERMS = 25,
  parameter int unsigned ADD_LAT   = 13,
  parameter int unsigned CNT_W     = $clog2(MAX_TERMS + 1),
  parameter int unsigned W         = 34
) (
  input  logic             clk,
  input  logic             RST_n,
  input  logic             start,
  input  logic [CNT_W-1:0] cfg_terms,
  input  logic             cfg_bias_en,
  input  logic [W-1:0]     bias,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [W-1:0]     out_data,
  input  logic             out_ready,
  output logic             busy,
  output logic [CNT_W-1:0] terms_done,
  output logic             err
);

  localparam int unsigned LAT_W = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IN = 2'd1,
    ADD     = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   n_q;
  logic [W-1:0]       acc;
  logic [W-1:0]       op;
  logic [LAT_W-1:0]   wait_cnt;
  logic [W-1:0]       add_r;

  logic               start_ok_c;
  logic               cfg_over_c;
  logic [CNT_W-1:0]   n_init_c;
  logic [W-1:0]       acc_init_c;
  logic               last_term_c;

  // Start is legal in IDLE, or in DONE when the result is being handed over
  assign start_ok_c  = start && ((state == IDLE) || ((state == DONE) && out_ready));
  assign cfg_over_c  = cfg_terms > CNT_W'(MAX_TERMS);
  assign n_init_c    = cfg_over_c ? CNT_W'(MAX_TERMS) : cfg_terms;
  assign acc_init_c  = cfg_bias_en ? bias : '0;
  assign last_term_c = (terms_done + CNT_W'(1)) == n_q;

  // Adder sees the held operand and the running sum for the whole ADD window
  FPAdd_8_23_F400_uid2 u_add (
    .clk (clk),
    .X   (op),
    .Y   (acc),
    .R   (add_r)
  );

  // Control FSM with all outputs registered
  always_ff @(posedge clk or negedge RST_n) begin
    if (!RST_n) begin
      state      <= IDLE;
      n_q        <= '0;
      acc        <= '0;
      op         <= '0;
      wait_cnt   <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      busy       <= 1'b0;
      terms_done <= '0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      if (start_ok_c) begin
        acc        <= acc_init_c;
        terms_done <= '0;
        n_q        <= n_init_c;
        busy       <= 1'b1;
        err        <= cfg_over_c;
        if (n_init_c == '0) begin
          state     <= DONE;
          out_valid <= 1'b1;
          out_data  <= acc_init_c;
          in_ready  <= 1'b0;
        end else begin
          state     <= WAIT_IN;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      end else begin
        // A start that cannot be taken is dropped but flagged
        if (start) begin
          err <= 1'b1;
        end
        case (state)
          WAIT_IN: begin
            if (in_valid) begin
              op       <= in_data;
              wait_cnt <= '0;
              in_ready <= 1'b0;
              state    <= ADD;
            end
          end
          ADD: begin
            if (wait_cnt == LAT_W'(ADD_LAT - 1)) begin
              acc        <= add_r;
              terms_done <= terms_done + CNT_W'(1);
              if (last_term_c) begin
                state     <= DONE;
                out_valid <= 1'b1;
                out_data  <= add_r;
              end else begin
                state    <= WAIT_IN;
                in_ready <= 1'b1;
              end
            end else begin
              wait_cnt <= wait_cnt + LAT_W'(1);
            end
          end
          DONE: begin
            if (out_ready) begin
              state     <= IDLE;
              out_valid <= 1'b0;
              busy      <= 1'b0;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// FloPoCo 8/23 adder, round-to-nearest-even, no subnormals (flush to zero).
// Word: {exn[1:0], sign, exp[7:0], frac[22:0]}; exn 00 zero, 01 normal,
// 10 infinity, 11 NaN. The result is produced DEPTH-1 registers after the
// operands; with the operand registers that feed it, launch-to-capture is
// DEPTH edges.
module FPAdd_8_23_F400_uid2 (
  input  logic        clk,
  input  logic [33:0] X,
  input  logic [33:0] Y,
  output logic [33:0] R
);

  localparam int unsigned DEPTH  = 13;
  localparam int unsigned STAGES = DEPTH - 1;
  localparam int unsigned FW     = 34;

  typedef struct packed {
    logic [1:0]  exn;
    logic        s;
    logic [7:0]  e;
    logic [22:0] f;
  } fp_t;

  fp_t                 x_c;
  fp_t                 y_c;
  fp_t                 a_c;
  fp_t                 b_c;
  fp_t                 norm_c;
  fp_t                 r_c;
  logic                swap_c;
  logic [7:0]          exp_diff_c;
  logic [26:0]         ma_c;
  logic [26:0]         mb_c;
  logic [26:0]         mb_sh_c;
  logic                sticky_c;
  logic                eff_sub_c;
  logic [27:0]         sum_c;
  logic [26:0]         norm_m_c;
  logic [4:0]          lz_c;
  logic signed [9:0]   exp_n_c;
  logic signed [9:0]   exp_r_c;
  logic                rnd_inc_c;
  logic [24:0]         mant_r_c;
  logic [22:0]         frac_r_c;
  logic [STAGES*FW-1:0] pipe;

  assign x_c = X;
  assign y_c = Y;

  // Position of the leading one in a 27-bit magnitude
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] cnt;
    cnt = 5'd0;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) begin
        cnt = 5'(26 - i);
      end
    end
    return cnt;
  endfunction

  // Finite-operand path: align, add/subtract, normalise, round
  always_comb begin
    swap_c     = {y_c.e, y_c.f} > {x_c.e, x_c.f};
    a_c        = swap_c ? y_c : x_c;
    b_c        = swap_c ? x_c : y_c;
    exp_diff_c = a_c.e - b_c.e;
    ma_c       = {1'b1, a_c.f, 3'b000};
    mb_c       = {1'b1, b_c.f, 3'b000};
    sticky_c   = 1'b0;
    mb_sh_c    = '0;
    if (exp_diff_c >= 8'd27) begin
      mb_sh_c = 27'd1;
    end else begin
      mb_sh_c    = mb_c >> exp_diff_c;
      sticky_c   = |(mb_c & ~(27'h7FF_FFFF << exp_diff_c));
      mb_sh_c[0] = mb_sh_c[0] | sticky_c;
    end
    eff_sub_c = a_c.s ^ b_c.s;
    sum_c     = eff_sub_c ? ({1'b0, ma_c} - {1'b0, mb_sh_c})
                          : ({1'b0, ma_c} + {1'b0, mb_sh_c});
    exp_n_c   = $signed({2'b00, a_c.e});
    lz_c      = 5'd0;
    norm_m_c  = '0;
    if (sum_c[27]) begin
      norm_m_c = {sum_c[27:2], sum_c[1] | sum_c[0]};
      exp_n_c  = exp_n_c + 10'sd1;
    end else begin
      lz_c     = lzc27(sum_c[26:0]);
      norm_m_c = sum_c[26:0] << lz_c;
      exp_n_c  = exp_n_c - $signed({5'b00000, lz_c});
    end
    rnd_inc_c = norm_m_c[2] & (norm_m_c[3] | norm_m_c[1] | norm_m_c[0]);
    mant_r_c  = {1'b0, norm_m_c[26:3]} + 25'(rnd_inc_c);
    exp_r_c   = exp_n_c;
    frac_r_c  = mant_r_c[22:0];
    if (mant_r_c[24]) begin
      exp_r_c  = exp_n_c + 10'sd1;
      frac_r_c = mant_r_c[23:1];
    end
    norm_c = '{exn: 2'b01, s: a_c.s, e: exp_r_c[7:0], f: frac_r_c};
    if (sum_c == '0) begin
      norm_c = '{exn: 2'b00, s: 1'b0, e: 8'd0, f: 23'd0};
    end else if (exp_r_c >= 10'sd255) begin
      norm_c = '{exn: 2'b10, s: a_c.s, e: 8'd0, f: 23'd0};
    end else if (exp_r_c <= 10'sd0) begin
      norm_c = '{exn: 2'b00, s: a_c.s, e: 8'd0, f: 23'd0};
    end
  end

  // Special-value resolution takes priority over the finite path
  always_comb begin
    r_c = norm_c;
    if ((x_c.exn == 2'b11) || (y_c.exn == 2'b11)) begin
      r_c = '{exn: 2'b11, s: 1'b0, e: 8'd0, f: 23'd0};
    end else if ((x_c.exn == 2'b10) && (y_c.exn == 2'b10)) begin
      r_c = (x_c.s != y_c.s) ? '{exn: 2'b11, s: 1'b0, e: 8'd0, f: 23'd0}
                             : '{exn: 2'b10, s: x_c.s, e: 8'd0, f: 23'd0};
    end else if (x_c.exn == 2'b10) begin
      r_c = '{exn: 2'b10, s: x_c.s, e: 8'd0, f: 23'd0};
    end else if (y_c.exn == 2'b10) begin
      r_c = '{exn: 2'b10, s: y_c.s, e: 8'd0, f: 23'd0};
    end else if ((x_c.exn == 2'b00) && (y_c.exn == 2'b00)) begin
      r_c = '{exn: 2'b00, s: x_c.s & y_c.s, e: 8'd0, f: 23'd0};
    end else if (x_c.exn == 2'b00) begin
      r_c = y_c;
    end else if (y_c.exn == 2'b00) begin
      r_c = x_c;
    end
  end

  // Result delay line matching the fixed pipeline depth
  always_ff @(posedge clk) begin
    pipe <= {pipe[(STAGES-1)*FW-1:0], r_c};
  end

  assign R = pipe[STAGES*FW-1 -: FW];

endmodule

// File: tb/tb_fp_mac_acc_seq.sv
// Directed bench for fp_mac_acc_seq: sums, bias, stalls, zero terms,
// saturation, illegal start, back-pressure/back-to-back, mid-run reset.

module tb_fp_mac_acc_seq;

  localparam logic [33:0] F1 = 34'h1_3F80_0000;
  localparam logic [33:0] F2 = 34'h1_4000_0000;
  localparam logic [33:0] F3 = 34'h1_4040_0000;

  logic        clk;
  logic        RST_n;
  logic        start;
  logic [4:0]  cfg_terms;
  logic        cfg_bias_en;
  logic [33:0] bias;
  logic        in_valid;
  logic [33:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [33:0] out_data;
  logic        out_ready;
  logic        busy;
  logic [4:0]  terms_done;
  logic        err;

  int          n_cmp;
  int          n_mis;
  int          lat;
  int          nacc;
  int          nerr;
  logic [33:0] tv [0:31];
  logic [33:0] hold;
  bit          stable;

  fp_mac_acc_seq dut (
    .clk         (clk),
    .RST_n       (RST_n),
    .start       (start),
    .cfg_terms   (cfg_terms),
    .cfg_bias_en (cfg_bias_en),
    .bias        (bias),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy),
    .terms_done  (terms_done),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_start(input logic [4:0] terms, input logic ben, input logic [33:0] b);
    cfg_terms   = terms;
    cfg_bias_en = ben;
    bias        = b;
    start       = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Feeds tv[] until out_valid; optional input gap and one illegal start pulse
  task automatic run(input int n_feed, input int gap_at, input int gap_len,
                     input int poke_at, input int budget,
                     output int o_lat, output int o_acc, output int o_err);
    int stall;
    bit poked;
    bit take;
    o_lat = 0;
    o_acc = 0;
    o_err = 0;
    stall = 0;
    poked = 1'b0;
    while (!out_valid && o_lat < budget) begin
      start = 1'b0;
      if (o_acc < n_feed) begin
        if (o_acc == gap_at && stall < gap_len && in_ready) begin
          in_valid = 1'b0;
          stall++;
        end else begin
          in_valid = 1'b1;
          in_data  = tv[o_acc];
        end
      end else begin
        in_valid = 1'b0;
      end
      if (!poked && o_acc == poke_at && !in_ready) begin
        start = 1'b1;
        poked = 1'b1;
      end
      take = in_valid && in_ready;
      @(posedge clk);
      o_lat++;
      #1;
      if (take) o_acc++;
      if (err) o_err++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    RST_n = 1'b0;
    start = 1'b0;
    cfg_terms = '0;
    cfg_bias_en = 1'b0;
    bias = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 32; i++) tv[i] = F1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_terms_done", 64'(terms_done), 64'd0);
    RST_n = 1'b1;
    @(posedge clk);
    #1;

    // Nine terms of 1.0, in_valid held high
    do_start(5'd9, 1'b0, '0);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_in_ready", 64'(in_ready), 64'd1);
    run(9, -1, 0, -1, 200, lat, nacc, nerr);
    chk("t1_latency", 64'(lat), 64'd126);
    chk("t1_out_data", 64'(out_data), 64'h1_4110_0000);
    chk("t1_terms_done", 64'(terms_done), 64'd9);
    chk("t1_err_count", 64'(nerr), 64'd0);
    @(posedge clk);
    #1;
    chk("t1_idle_valid", 64'(out_valid), 64'd0);
    chk("t1_idle_busy", 64'(busy), 64'd0);

    // Bias 2.0 plus 1.0 and 3.0 with a 5-cycle input gap
    tv[0] = F1;
    tv[1] = F3;
    do_start(5'd2, 1'b1, F2);
    run(2, 1, 5, -1, 100, lat, nacc, nerr);
    chk("t2_latency", 64'(lat), 64'd33);
    chk("t2_out_data", 64'(out_data), 64'h1_40C0_0000);
    chk("t2_terms_done", 64'(terms_done), 64'd2);
    @(posedge clk);
    #1;

    // Zero terms: bias comes straight out
    do_start(5'd0, 1'b1, F2);
    chk("t3_out_valid", 64'(out_valid), 64'd1);
    chk("t3_out_data", 64'(out_data), 64'h1_4000_0000);
    chk("t3_in_ready", 64'(in_ready), 64'd0);
    chk("t3_err", 64'(err), 64'd0);
    @(posedge clk);
    #1;
    chk("t3_idle", 64'(busy), 64'd0);

    // Saturating term count plus an illegal start during ADD
    for (int i = 0; i < 32; i++) tv[i] = F1;
    do_start(5'd31, 1'b0, '0);
    chk("t4_sat_err", 64'(err), 64'd1);
    run(30, -1, 0, 3, 400, lat, nacc, nerr);
    chk("t4_latency", 64'(lat), 64'd350);
    chk("t4_accepted", 64'(nacc), 64'd25);
    chk("t4_terms_done", 64'(terms_done), 64'd25);
    chk("t4_illegal_err", 64'(nerr), 64'd1);
    chk("t4_out_data", 64'(out_data), 64'h1_41C8_0000);
    @(posedge clk);
    #1;

    // Back-pressure, then back-to-back start at handover
    out_ready = 1'b0;
    tv[0] = F1;
    tv[1] = F1;
    do_start(5'd2, 1'b0, '0);
    run(2, -1, 0, -1, 100, lat, nacc, nerr);
    chk("t5_latency", 64'(lat), 64'd28);
    chk("t5_out_data", 64'(out_data), 64'h1_4000_0000);
    hold = out_data;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (out_data !== hold || out_valid !== 1'b1) stable = 1'b0;
    end
    chk("t5_hold_stable", 64'(stable), 64'd1);
    out_ready = 1'b1;
    do_start(5'd1, 1'b1, F2);
    chk("t5_b2b_valid_low", 64'(out_valid), 64'd0);
    chk("t5_b2b_in_ready", 64'(in_ready), 64'd1);
    chk("t5_b2b_terms_done", 64'(terms_done), 64'd0);
    chk("t5_b2b_err", 64'(err), 64'd0);
    tv[0] = F3;
    run(1, -1, 0, -1, 100, lat, nacc, nerr);
    chk("t5_b2b_latency", 64'(lat), 64'd14);
    chk("t5_b2b_out_data", 64'(out_data), 64'h1_40A0_0000);
    @(posedge clk);
    #1;

    // Reset while the fourth of nine terms is in the adder
    in_valid = 1'b1;
    in_data  = F1;
    do_start(5'd9, 1'b0, '0);
    repeat (47) @(posedge clk);
    #1;
    chk("t6_pre_terms", 64'(terms_done), 64'd3);
    chk("t6_pre_in_ready", 64'(in_ready), 64'd0);
    RST_n = 1'b0;
    #1;
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_terms", 64'(terms_done), 64'd0);
    chk("t6_rst_out_data", 64'(out_data), 64'd0);
    chk("t6_rst_in_ready", 64'(in_ready), 64'd0);
    chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    RST_n = 1'b1;
    @(posedge clk);
    #1;
    tv[0] = F1;
    do_start(5'd1, 1'b0, '0);
    run(1, -1, 0, -1, 100, lat, nacc, nerr);
    chk("t6_latency", 64'(lat), 64'd14);
    chk("t6_out_data", 64'(out_data), 64'h1_3F80_0000);
    chk("t6_terms_done", 64'(terms_done), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
